// File: rtl/mem_lsu_ctrl.sv
// rtl/mem_lsu_ctrl.sv - load/store sequencer with misaligned split, lane mapping and load extension
module mem_lsu_ctrl #(
    parameter int ADDRESS_WIDTH    = 4,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [1:0]                 req_size,
    input  logic                       req_unsigned,
    input  logic [ADDRESS_WIDTH+1:0]   req_addr,
    input  logic [31:0]                req_wdata,
    output logic                       rsp_valid,
    output logic                       rsp_err,
    output logic [31:0]                rsp_rdata,
    output logic [3:0]                 mem_byte_enable,
    output logic [ADDRESS_WIDTH-1:0]   mem_addr,
    output logic [31:0]                mem_din,
    input  logic [31:0]                mem_dout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_CAP,
        S_DONE
    } state_t;

    state_t                     state;
    logic                       we_q;
    logic [1:0]                 size_q;
    logic                       uns_q;
    logic [1:0]                 off_q;
    logic [ADDRESS_WIDTH-1:0]   word_q;
    logic [31:0]                wdata_q;
    logic                       err_q;
    logic [31:0]                lo_word;
    logic [31:0]                hi_word;
    logic [31:0]                rdata_q;

    // Lane mask across two consecutive words: low nibble is the first word, high nibble the next
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [7:0] base;
        case (size)
            2'b00:   base = 8'h01;
            2'b01:   base = 8'h03;
            default: base = 8'h0F;
        endcase
        return base << off;
    endfunction

    // Shift the two-word window down to the access and sign/zero-extend to 32 bits
    function automatic logic [31:0] assemble(input logic [31:0] lo, input logic [31:0] hi,
                                             input logic [1:0] off, input logic [1:0] size,
                                             input logic uns);
        logic [63:0] r;
        logic [31:0] res;
        r = {hi, lo} >> {off, 3'b000};
        case (size)
            2'b00:   res = {{24{~uns & r[7]}}, r[7:0]};
            2'b01:   res = {{16{~uns & r[15]}}, r[15:0]};
            default: res = r[31:0];
        endcase
        return res;
    endfunction

    logic [7:0]  req_mask;
    logic        req_split;
    logic [7:0]  mask8;
    logic        split;
    logic [63:0] store_shifted;
    logic [31:0] cap_lo;
    logic [31:0] cap_hi;

    // Decode of the incoming request and of the latched request
    always_comb begin
        req_mask      = lane_mask(req_size, req_addr[1:0]);
        req_split     = |req_mask[7:4];
        mask8         = lane_mask(size_q, off_q);
        split         = |mask8[7:4];
        store_shifted = {32'h0, wdata_q} << {off_q, 3'b000};
        cap_lo        = split ? lo_word : mem_dout;
        cap_hi        = split ? mem_dout : 32'h0;
    end

    // Sequencer: accept, issue one or two memory cycles, capture read data, respond
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            off_q   <= 2'b00;
            word_q  <= '0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
            lo_word <= 32'h0;
            hi_word <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        off_q   <= req_addr[1:0];
                        word_q  <= req_addr[ADDRESS_WIDTH+1:2];
                        wdata_q <= req_wdata;
                        if (req_size == 2'b11 || (!ALLOW_MISALIGNED && req_split)) begin
                            err_q   <= 1'b1;
                            rdata_q <= 32'h0;
                            state   <= S_DONE;
                        end else begin
                            err_q   <= 1'b0;
                            state   <= S_LO;
                        end
                    end
                end
                S_LO: begin
                    if (split) begin
                        state <= S_HI;
                    end else if (we_q) begin
                        rdata_q <= 32'h0;
                        state   <= S_DONE;
                    end else begin
                        state <= S_CAP;
                    end
                end
                S_HI: begin
                    if (we_q) begin
                        rdata_q <= 32'h0;
                        state   <= S_DONE;
                    end else begin
                        lo_word <= mem_dout;
                        state   <= S_CAP;
                    end
                end
                S_CAP: begin
                    if (split) begin
                        hi_word <= mem_dout;
                    end else begin
                        lo_word <= mem_dout;
                    end
                    rdata_q <= assemble(cap_lo, cap_hi, off_q, size_q, uns_q);
                    state   <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Memory-side drive decoded from state; idle, capture and response states leave the bus quiet
    always_comb begin
        mem_addr        = '0;
        mem_byte_enable = 4'h0;
        mem_din         = 32'h0;
        case (state)
            S_LO: begin
                mem_addr = word_q;
                if (we_q) begin
                    mem_byte_enable = mask8[3:0];
                    mem_din         = store_shifted[31:0];
                end
            end
            S_HI: begin
                mem_addr = word_q + ADDRESS_WIDTH'(1);
                if (we_q) begin
                    mem_byte_enable = mask8[7:4];
                    mem_din         = store_shifted[63:32];
                end
            end
            default: begin
                mem_addr = '0;
            end
        endcase
    end

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_DONE);
    assign rsp_err   = (state == S_DONE) & err_q;
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_lsu_ctrl.sv
// tb/tb_mem_lsu_ctrl.sv - self-checking bench for mem_lsu_ctrl against a byte-array reference
module tb_mem_lsu_ctrl;
    localparam int AW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]    req_size;
    logic [AW+1:0] req_addr;
    logic [31:0]   req_wdata, rsp_rdata, mem_din, mem_dout;
    logic          rsp_valid, rsp_err;
    logic [3:0]    mem_byte_enable;
    logic [AW-1:0] mem_addr;

    logic          n_valid, n_ready, n_we, n_uns, n_rsp_valid, n_rsp_err;
    logic [1:0]    n_size;
    logic [AW+1:0] n_addr;
    logic [31:0]   n_wdata, n_rdata, n_din;
    logic [31:0]   n_dout = 32'h0;
    logic [3:0]    n_be;
    logic [AW-1:0] n_maddr;

    mem_lsu_ctrl #(.ADDRESS_WIDTH(AW), .ALLOW_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .mem_byte_enable(mem_byte_enable),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    mem_lsu_ctrl #(.ADDRESS_WIDTH(AW), .ALLOW_MISALIGNED(1'b0)) dut_nm (
        .clk(clk), .rst_n(rst_n), .req_valid(n_valid), .req_ready(n_ready),
        .req_we(n_we), .req_size(n_size), .req_unsigned(n_uns),
        .req_addr(n_addr), .req_wdata(n_wdata), .rsp_valid(n_rsp_valid),
        .rsp_err(n_rsp_err), .rsp_rdata(n_rdata), .mem_byte_enable(n_be),
        .mem_addr(n_maddr), .mem_din(n_din), .mem_dout(n_dout)
    );

    // Write-first synchronous-read memory with a preload port for the bench
    logic [31:0]   mem [16];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_idx = '0;
    logic [31:0]   pre_val = 32'h0;
    logic [31:0]   merged;

    function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [31:0] d,
                                               input logic [3:0] be);
        logic [31:0] w;
        w = old;
        for (int k = 0; k < 4; k++) if (be[k]) w[8*k +: 8] = d[8*k +: 8];
        return w;
    endfunction

    assign merged = merge_word(mem[mem_addr], mem_din, mem_byte_enable);

    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_val;
        else        mem[mem_addr] <= merged;
        mem_dout <= merged;
    end

    // Reference: flat byte memory, 64 bytes, addresses wrap modulo 64
    logic [7:0] refb [64];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input int addr, input int size, input logic uns);
        logic [31:0] v;
        int n;
        n = 1 << size;
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = refb[(addr + i) % 64];
        if (size == 0 && !uns && v[7])  v[31:8]  = 24'hFFFFFF;
        if (size == 1 && !uns && v[15]) v[31:16] = 16'hFFFF;
        return v;
    endfunction

    task automatic set_word(input int idx, input logic [31:0] val);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = AW'(idx); pre_val = val;
        @(posedge clk); #1 pre_we = 1'b0;
        for (int i = 0; i < 4; i++) refb[4*idx + i] = val[8*i +: 8];
    endtask

    logic [AW-1:0] lg_addr [0:8];
    logic [3:0]    lg_be   [0:8];
    logic [31:0]   lg_din  [0:8];
    int            lat;
    logic          got_err;
    logic [31:0]   got_rd;
    logic [3:0]    any_be;

    // One request through the main DUT, compared with the byte-level reference
    task automatic txn(input string tag, input logic we, input int size, input logic uns,
                       input int addr, input logic [31:0] wdata);
        int n, off, exp_lat;
        logic spl, err;
        logic [31:0] exp_rd;
        n = 1 << size; off = addr % 4;
        spl = (off + n) > 4;
        err = (size == 3);
        exp_lat = err ? 1 : (we ? (spl ? 3 : 2) : (spl ? 4 : 3));
        exp_rd = (err || we) ? 32'h0 : ref_load(addr, size, uns);
        @(negedge clk);
        chk({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
        req_we = we; req_size = size[1:0]; req_unsigned = uns;
        req_addr = addr[AW+1:0]; req_wdata = wdata; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        lat = 0; any_be = 4'h0; got_err = 1'b0; got_rd = 32'h0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(negedge clk);
            lg_addr[c] = mem_addr; lg_be[c] = mem_byte_enable; lg_din[c] = mem_din;
            any_be = any_be | mem_byte_enable;
            if (rsp_valid) begin lat = c; got_err = rsp_err; got_rd = rsp_rdata; end
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_err"}, {31'h0, got_err}, {31'h0, err});
        chk({tag, "_rdata"}, got_rd, exp_rd);
        if (!we || err) chk({tag, "_be_quiet"}, {28'h0, any_be}, 32'h0);
        if (we && !err) for (int i = 0; i < n; i++) refb[(addr + i) % 64] = wdata[8*i +: 8];
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = 32'h0;
        n_valid = 1'b0; n_we = 1'b0; n_size = 2'b00; n_uns = 1'b0; n_addr = '0; n_wdata = 32'h0;
        #12;
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_err",   {31'h0, rsp_err}, 32'h0);
        chk("rst_rdata",     rsp_rdata, 32'h0);
        chk("rst_be",        {28'h0, mem_byte_enable}, 32'h0);
        chk("rst_addr",      {28'h0, mem_addr}, 32'h0);
        chk("rst_din",       mem_din, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'h0, req_ready}, 32'h1);

        for (int i = 0; i < 16; i++) set_word(i, $urandom);
        set_word(0, 32'h44332211);
        set_word(1, 32'h88776655);
        set_word(15, 32'hDDCCBBAA);

        txn("lw0", 1'b0, 2, 1'b0, 0, 32'h0);
        chk("lw0_const", got_rd, 32'h44332211);
        chk("lw0_addr_c1", {28'h0, lg_addr[1]}, 32'h0);
        txn("lb7", 1'b0, 0, 1'b0, 7, 32'h0);
        chk("lb7_const", got_rd, 32'hFFFFFF88);
        txn("lbu7", 1'b0, 0, 1'b1, 7, 32'h0);
        chk("lbu7_const", got_rd, 32'h00000088);
        txn("lh4", 1'b0, 1, 1'b0, 4, 32'h0);
        chk("lh4_const", got_rd, 32'h00006655);

        txn("lw2", 1'b0, 2, 1'b0, 2, 32'h0);
        chk("lw2_const", got_rd, 32'h66554433);
        chk("lw2_addr_lo", {28'h0, lg_addr[1]}, 32'h0);
        chk("lw2_addr_hi", {28'h0, lg_addr[2]}, 32'h1);

        @(negedge clk);
        n_we = 1'b0; n_size = 2'b10; n_addr = 6'd2; n_valid = 1'b1;
        @(posedge clk); #1 n_valid = 1'b0;
        @(negedge clk);
        chk("nm_valid_c1", {31'h0, n_rsp_valid}, 32'h1);
        chk("nm_err_c1",   {31'h0, n_rsp_err}, 32'h1);
        chk("nm_rdata",    n_rdata, 32'h0);
        chk("nm_be",       {28'h0, n_be}, 32'h0);
        chk("nm_addr",     {28'h0, n_maddr}, 32'h0);

        txn("lw62", 1'b0, 2, 1'b0, 62, 32'h0);
        chk("lw62_const", got_rd, 32'h2211DDCC);
        chk("lw62_wrap", {28'h0, lg_addr[2]}, 32'h0);

        txn("sh3", 1'b1, 1, 1'b0, 3, 32'h0000BEEF);
        chk("sh3_lo_addr", {28'h0, lg_addr[1]}, 32'h0);
        chk("sh3_lo_be",   {28'h0, lg_be[1]}, 32'h8);
        chk("sh3_lo_din",  {24'h0, lg_din[1][31:24]}, 32'hEF);
        chk("sh3_hi_addr", {28'h0, lg_addr[2]}, 32'h1);
        chk("sh3_hi_be",   {28'h0, lg_be[2]}, 32'h1);
        chk("sh3_hi_din",  {24'h0, lg_din[2][7:0]}, 32'hBE);
        txn("rb0", 1'b0, 2, 1'b0, 0, 32'h0);
        chk("rb0_const", got_rd, 32'hEF332211);
        txn("rb4", 1'b0, 2, 1'b0, 4, 32'h0);
        chk("rb4_const", got_rd, 32'h887766BE);

        txn("sz3", 1'b0, 3, 1'b0, 1, 32'h0);

        for (int t = 0; t < 60; t++) begin
            int r;
            r = $urandom_range(0, 9);
            txn("rnd", 1'($urandom_range(0, 1)), (r == 9) ? 3 : (r % 3),
                1'($urandom_range(0, 1)), $urandom_range(0, 63), $urandom);
        end

        set_word(2, 32'h5A5A5A5A);
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 6'd5;
        req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rst_lo_be",   {28'h0, mem_byte_enable}, 32'hE);
        chk("rst_lo_addr", {28'h0, mem_addr}, 32'h1);
        @(posedge clk); #2;
        chk("rst_hi_be", {28'h0, mem_byte_enable}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_be",    {28'h0, mem_byte_enable}, 32'h0);
        chk("rst_mid_valid", {31'h0, rsp_valid}, 32'h0);
        refb[5] = 8'h0D; refb[6] = 8'hF0; refb[7] = 8'hFE;
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rst_no_rsp", {31'h0, rsp_valid}, 32'h0);
        end
        chk("rst_rel_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_word2", mem[2], 32'h5A5A5A5A);

        for (int i = 0; i < 16; i++)
            chk($sformatf("mem_w%0d", i), mem[i],
                {refb[4*i+3], refb[4*i+2], refb[4*i+1], refb[4*i]});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
